tcam_16x16: RTL and testbench



---
 rtl/tcam_16x16_pkg.sv | 17 +
 rtl/tcam_16x16_if.sv | 28 ++
 rtl/tcam_16x16_entry.sv | 42 ++++
 rtl/tcam_16x16.sv | 58 +++++
 tb/tb_tcam_16x16.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tcam_16x16_pkg.sv
// Shared sizing, types and the ternary match rule for the 16x16 TCAM.
package tcam_16x16_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [DEPTH-1:0] hit_vec_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // A set mask bit removes that bit position from the comparison.
  function automatic logic ternary_match(input word_t key, input word_t data, input word_t mask);
    return ((key ^ data) & ~mask) == '0;
  endfunction

endpackage

// File: rtl/tcam_16x16_if.sv
// Write/search bus of the TCAM: the requester drives the master side, the table the slave side.
interface tcam_16x16_if
  import tcam_16x16_pkg::*;
  ;

  logic     write_enable;
  word_t    input_data;
  word_t    input_unknown_bits;
  hit_vec_t htis;
  logic     write_success;

  modport master (
    output write_enable,
    output input_data,
    output input_unknown_bits,
    input  htis,
    input  write_success
  );

  modport slave (
    input  write_enable,
    input  input_data,
    input  input_unknown_bits,
    output htis,
    output write_success
  );

endinterface

// File: rtl/tcam_16x16_entry.sv
// One TCAM slot: stored word, don't-care mask, valid flag and its own match comparator.
module tcam_entry
  import tcam_16x16_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  word_t wr_data,
  input  word_t wr_mask,
  input  word_t key,
  output logic  hit
);

  word_t data_q, data_d;
  word_t mask_q, mask_d;
  logic  valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d  = wr_data;
      mask_d  = wr_mask;
      valid_d = 1'b1;
    end
  end

  // Contents need no reset: a cleared valid flag hides whatever is stored.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    mask_q <= mask_d;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  assign hit = valid_q & ternary_match(key, data_q, mask_q);

endmodule

// File: rtl/tcam_16x16.sv
// 16-entry ternary CAM: fill-in-order write pointer, parallel combinational search.
module tcam_16x16
  import tcam_16x16_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  tcam_16x16_if.slave  bus
);

  ptr_t     wr_ptr_q, wr_ptr_d;
  logic     full_q, full_d;
  logic     write_success_q, write_success_d;
  hit_vec_t wr_sel;
  hit_vec_t hit_raw;

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    full_d          = full_q;
    write_success_d = 1'b0;
    wr_sel          = '0;
    if (bus.write_enable && !full_q) begin
      wr_sel[wr_ptr_q] = 1'b1;
      write_success_d  = 1'b1;
      // The last slot parks the pointer and raises full instead of wrapping.
      if (wr_ptr_q == ptr_t'(DEPTH - 1)) full_d = 1'b1;
      else                               wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      full_q          <= 1'b0;
      write_success_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      full_q          <= full_d;
      write_success_q <= write_success_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    tcam_entry u_entry (
      .clk     (clk),
      .rst     (reset),
      .wr_en   (wr_sel[i]),
      .wr_data (bus.input_data),
      .wr_mask (bus.input_unknown_bits),
      .key     (bus.input_data),
      .hit     (hit_raw[i])
    );
  end

  // input_data carries write data on write cycles, so hits are only meaningful when searching.
  assign bus.htis          = (bus.write_enable || reset) ? '0 : hit_raw;
  assign bus.write_success = write_success_q;

endmodule

// File: tb/tb_tcam_16x16.sv
// Self-checking bench for tcam_16x16 against a queue-based table model.
module tb_tcam_16x16;
  import tcam_16x16_pkg::*;

  logic clk;
  logic reset;
  tcam_16x16_if bus ();

  tcam_16x16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [15:0] data;
    logic [15:0] mask;
  } entry_t;

  entry_t tbl[$];

  function automatic logic [15:0] ref_hits(input logic [15:0] key);
    logic [15:0] h;
    h = '0;
    foreach (tbl[i])
      if (((key ^ tbl[i].data) & ~tbl[i].mask) == 16'h0) h[i] = 1'b1;
    return h;
  endfunction

  function automatic logic model_write(input logic [15:0] d, input logic [15:0] m);
    entry_t e;
    if (tbl.size() >= 16) return 1'b0;
    e.data = d;
    e.mask = m;
    tbl.push_back(e);
    return 1'b1;
  endfunction

  task automatic apply_write(input logic [15:0] d, input logic [15:0] m);
    bus.write_enable       = 1'b1;
    bus.input_data         = d;
    bus.input_unknown_bits = m;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic apply_search(input logic [15:0] key);
    bus.write_enable       = 1'b0;
    bus.input_data         = key;
    bus.input_unknown_bits = 16'($urandom);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tbl.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.write_enable = 1'b0;
    bus.input_data = 16'h04D2;
    bus.input_unknown_bits = 16'h0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.htis !== 16'h0) begin
      n_bad++;
      $display("FAIL htis_during_reset: got %h expected 0000", bus.htis);
    end
    reset = 1'b0;
    tbl.delete();
    apply_search(16'h04D2);
    n_cmp++;
    if (bus.htis !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_search: got %h expected 0000", bus.htis);
    end
    n_cmp++;
    if (bus.write_success !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_write_success: got %b expected 0", bus.write_success);
    end
  endtask

  task automatic test_directed_fill();
    logic [15:0] wd[5] = '{16'h0060, 16'h007E, 16'h00E9, 16'h00E9, 16'h0000};
    logic [15:0] wm[5] = '{16'h000F, 16'h0052, 16'h0000, 16'h0087, 16'hFFFF};
    logic exp_ws;
    logic [15:0] exp_h;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      bus.write_enable = 1'b1;
      bus.input_data = wd[i];
      bus.input_unknown_bits = wm[i];
      #1;
      n_cmp++;
      if (bus.htis !== 16'h0) begin
        n_bad++;
        $display("FAIL htis_during_write[%0d]: got %h expected 0000", i, bus.htis);
      end
      exp_ws = model_write(wd[i], wm[i]);
      apply_write(wd[i], wm[i]);
      n_cmp++;
      if (bus.write_success !== exp_ws || exp_ws !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_write_success[%0d]: got %b expected 1", i, bus.write_success);
      end
    end
    apply_search(16'h006E);
    exp_h = ref_hits(16'h006E);
    n_cmp++;
    if (bus.htis !== 16'h001B || exp_h !== 16'h001B) begin
      n_bad++;
      $display("FAIL search_006E: got %h expected 001b (model %h)", bus.htis, exp_h);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.write_success !== 1'b0) begin
      n_bad++;
      $display("FAIL search_edge_write_success: got %b expected 0", bus.write_success);
    end
  endtask

  task automatic test_full_boundary();
    logic exp_ws;
    logic [15:0] exp_h;
    for (int i = 0; i < 14; i++) begin
      exp_ws = model_write(16'h0000, 16'hFFFF);
      apply_write(16'h0000, 16'hFFFF);
      n_cmp++;
      if (bus.write_success !== exp_ws || exp_ws !== (i < 11)) begin
        n_bad++;
        $display("FAIL full_write_success[%0d]: got %b expected %b", i, bus.write_success, (i < 11));
      end
    end
    apply_search(16'h04D2);
    exp_h = ref_hits(16'h04D2);
    n_cmp++;
    if (bus.htis !== 16'hFFF0 || exp_h !== 16'hFFF0) begin
      n_bad++;
      $display("FAIL search_04D2_full: got %h expected fff0", bus.htis);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.htis !== 16'h0) begin
      n_bad++;
      $display("FAIL htis_forced_by_reset: got %h expected 0000", bus.htis);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_refill();
    apply_reset();
    apply_search(16'h0000);
    n_cmp++;
    if (bus.htis !== 16'h0) begin
      n_bad++;
      $display("FAIL after_reset_search: got %h expected 0000", bus.htis);
    end
    void'(model_write(16'h1234, 16'h0000));
    apply_write(16'h1234, 16'h0000);
    n_cmp++;
    if (bus.write_success !== 1'b1) begin
      n_bad++;
      $display("FAIL refill_write_success: got %b expected 1", bus.write_success);
    end
    apply_search(16'h1234);
    n_cmp++;
    if (bus.htis !== 16'h0001) begin
      n_bad++;
      $display("FAIL refill_search_1234: got %h expected 0001", bus.htis);
    end
    apply_search(16'h1235);
    n_cmp++;
    if (bus.htis !== 16'h0000) begin
      n_bad++;
      $display("FAIL refill_search_1235: got %h expected 0000", bus.htis);
    end
  endtask

  task automatic test_random();
    logic [15:0] d, m, key, exp_h;
    logic exp_ws;
    for (int round = 0; round < 3; round++) begin
      apply_reset();
      for (int op = 0; op < 60; op++) begin
        if ($urandom_range(0, 1) == 0) begin
          d = 16'($urandom);
          case ($urandom_range(0, 3))
            0:       m = 16'h0000;
            1:       m = 16'h00FF;
            2:       m = 16'($urandom) & 16'($urandom);
            default: m = 16'($urandom);
          endcase
          exp_ws = model_write(d, m);
          apply_write(d, m);
          n_cmp++;
          if (bus.write_success !== exp_ws) begin
            n_bad++;
            $display("FAIL rand_write_success r%0d op%0d: got %b expected %b", round, op, bus.write_success, exp_ws);
          end
        end else begin
          if (tbl.size() > 0 && $urandom_range(0, 3) != 0)
            key = tbl[$urandom_range(0, tbl.size() - 1)].data ^ (16'(1) << $urandom_range(0, 15));
          else
            key = 16'($urandom);
          apply_search(key);
          exp_h = ref_hits(key);
          n_cmp++;
          if (bus.htis !== exp_h) begin
            n_bad++;
            $display("FAIL rand_search r%0d op%0d key %h: got %h expected %h", round, op, key, bus.htis, exp_h);
          end
          @(posedge clk);
          #1;
          n_cmp++;
          if (bus.write_success !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_search_ws r%0d op%0d: got %b expected 0", round, op, bus.write_success);
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.write_enable = 1'b0;
    bus.input_data = '0;
    bus.input_unknown_bits = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed_fill();
    test_full_boundary();
    test_reset_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
